parity_check_rx: RTL and testbench
==================================

PARITY_CHECK_RX -- requirements
Module: parity_check_rx

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame (range 2..32).
REQ-002 Parameter ODD_PARITY, default 0; 0 = even parity expected, 1 = odd parity expected.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 x  input  1  serial bit; data bits LSB first, then one parity bit.
REQ-006 x_valid  input  1  x is sampled only when x_valid=1.
REQ-007 sof  input  1  start-of-frame; qualified by x_valid and marks x as data bit 0.
REQ-008 data_out  output  DATA_W  last completed frame's data word.
REQ-009 data_valid  output  1  one-cycle pulse when data_out/par_err update.
REQ-010 par_err  output  1  parity mismatch flag for the last completed frame.
REQ-011 z  output  1  running XOR of bits accepted so far in the current frame, parity bit included.
REQ-012 busy  output  1  high while in DATA or PARITY state.

Function
REQ-013 States IDLE, DATA, PARITY, all registered; bit counter width ceil(log2(DATA_W+1)).
REQ-014 IDLE: x_valid=0 or sof=0 -> stay; x_valid=1 with sof=1 -> store x as bit 0, count=1, z=x, go DATA.
REQ-015 DATA: x_valid=1 -> store x at bit[count], count+1, z^=x; on storing bit DATA_W-1, go PARITY.
REQ-016 PARITY: x_valid=1 -> evaluate parity, go IDLE.
REQ-017 Any state with x_valid=0: state, count, shift register and z hold; gaps of any length are allowed.
REQ-018 Mismatch rule: par_err = (XOR of DATA_W data bits ^ parity bit) != ODD_PARITY.
REQ-019 Latency: data_out, par_err and data_valid update on the clock edge that samples the parity bit; data_valid is high for exactly one cycle after that edge.
REQ-020 data_out and par_err hold their values until the next completed frame.
REQ-021 sof=1 with x_valid=1 in DATA or PARITY aborts the current frame: no data_valid for it; x becomes bit 0 of a new frame; z=x; count=1; go DATA.
REQ-022 sof=1 with x_valid=1 on the cycle immediately after the parity bit is accepted (back-to-back frames) starts a new frame with no lost bit.
REQ-023 sof with x_valid=0 is ignored in every state.
REQ-024 x_valid=1 with sof=0 in IDLE is ignored; z holds.

Reset
REQ-025 rst_n=0 immediately forces: state IDLE, count 0, shift register 0, data_out 0, data_valid 0, par_err 0, z 0, busy 0, err_count 0.
REQ-026 Reset mid-frame discards the partial frame; the first frame after release decodes normally.

Configuration
REQ-027 Macro PARITY_ERR_CNT_EN defined: adds output err_count (8 bits), incremented by 1 on each completed frame with par_err=1, saturating at 255, reset to 0.
REQ-028 PARITY_ERR_CNT_EN undefined: err_count port and its logic are absent; all other behaviour is identical.

Verification (DATA_W=8, ODD_PARITY=0 unless stated)
REQ-029 Bits 1,0,1,0,0,1,0,1 (sof on first) with parity 0 -> data_out=0xA5, par_err=0, one data_valid pulse, z=0 after the parity bit.
REQ-030 Same data with parity 1 -> data_out=0xA5, par_err=1, err_count=1 (macro on); with ODD_PARITY=1 the same frame -> par_err=0.
REQ-031 Frame 0x3C with 0-5 idle x_valid=0 cycles between bits -> data_out=0x3C, par_err=0, busy high throughout.
REQ-032 After 4 bits of one frame, sof with new frame 0xFF, parity 0 -> exactly one data_valid pulse; data_out=0xFF, par_err=0.
REQ-033 rst_n low after 5 bits, then frame 0x01 with parity 1 -> all outputs 0 during reset; then data_out=0x01, par_err=0.
REQ-034 Back-to-back frames 0x12/parity 0 and 0x34/parity 1, no gap -> two data_valid pulses: 0x12 with par_err=0, then 0x34 with par_err=0; 256 error frames -> err_count=255.

Source files
------------

// File: rtl/parity_check_rx.sv
// parity_check_rx: serial frame receiver with parity check.
// A frame is DATA_W data bits (LSB first) followed by one parity bit. The
// first data bit is marked by sof. Bits are accepted only when x_valid=1;
// gaps of any length between bits are allowed. A sof in mid-frame aborts
// the current frame and starts a new one with that bit.
// Optional feature: define PARITY_ERR_CNT_EN to add an 8-bit saturating
// count of frames received with a parity error (err_count).
module parity_check_rx #(
   parameter int DATA_W     = 8,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              x,
   input  logic              x_valid,
   input  logic              sof,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              par_err,
   output logic              z,
   output logic              busy
`ifdef PARITY_ERR_CNT_EN
   ,
   output logic [7:0]        err_count
`endif
);

   localparam int CW = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY
   } state_t;

   state_t            state, state_next;
   logic [CW-1:0]     count, count_next;
   logic [DATA_W-1:0] shreg, shreg_next;
   logic              z_next;
   logic              frame_done;
   logic              frame_err;

   // Next-state and datapath decode: sof always wins, then per-state bit handling.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_next = state;
      count_next = count;
      shreg_next = shreg;
      z_next     = z;
      frame_done = 1'b0;
      frame_err  = (((^shreg) ^ x) != ODD_PARITY);

      if (x_valid) begin
         if (sof) begin
            // New frame, also when it aborts a frame in progress.
            state_next = S_DATA;
            count_next = CW'(1);
            shreg_next = DATA_W'(x);
            z_next     = x;
         end else begin
            case (state)
               S_DATA: begin
                  for (int i = 0; i < DATA_W; i++) begin
                     if (count == CW'(i)) shreg_next[i] = x;
                  end
                  count_next = count + CW'(1);
                  z_next     = z ^ x;
                  if (count == CW'(DATA_W - 1)) state_next = S_PARITY;
               end
               S_PARITY: begin
                  z_next     = z ^ x;
                  frame_done = 1'b1;
                  count_next = '0;
                  state_next = S_IDLE;
               end
               default: ;  // IDLE without sof: bit is ignored
            endcase
         end
      end
   end

   // Frame state register: FSM state, bit counter, shift register, running XOR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         count <= '0;
         shreg <= '0;
         z     <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values regardless of statement order.
         state <= state_next;
         count <= count_next;
         shreg <= shreg_next;
         z     <= z_next;
      end
   end

   // Result registers: publish the word and parity verdict when a frame completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out   <= '0;
         par_err    <= 1'b0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= frame_done;
         if (frame_done) begin
            data_out <= shreg;
            par_err  <= frame_err;
         end
      end
   end

`ifdef PARITY_ERR_CNT_EN
   // Saturating count of completed frames that failed the parity check.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (frame_done && frame_err && (err_count != 8'hFF)) begin
         err_count <= err_count + 8'd1;
      end
   end
`endif

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_parity_check_rx.sv
// Directed testbench for parity_check_rx (DATA_W=8). An even-parity and an
// odd-parity instance share the same stimulus. err_count is checked only
// when PARITY_ERR_CNT_EN is defined.
module tb_parity_check_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       x = 1'b0;
   logic       x_valid = 1'b0;
   logic       sof = 1'b0;

   logic [7:0] data_out, data_out_o;
   logic       data_valid, data_valid_o;
   logic       par_err, par_err_o;
   logic       z, z_o;
   logic       busy, busy_o;
`ifdef PARITY_ERR_CNT_EN
   logic [7:0] err_count, err_count_o;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int dv_cnt  = 0;
   int dv_base = 0;

   parity_check_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .sof(sof),
      .data_out(data_out), .data_valid(data_valid), .par_err(par_err),
      .z(z), .busy(busy)
`ifdef PARITY_ERR_CNT_EN
      , .err_count(err_count)
`endif
   );

   parity_check_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) dut_odd (
      .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .sof(sof),
      .data_out(data_out_o), .data_valid(data_valid_o), .par_err(par_err_o),
      .z(z_o), .busy(busy_o)
`ifdef PARITY_ERR_CNT_EN
      , .err_count(err_count_o)
`endif
   );

   always #5 clk = ~clk;

   // Count data_valid pulses of the even-parity instance, sampled after each edge.
   always @(posedge clk) begin
      #1;
      if (data_valid === 1'b1) dv_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_now(input logic b, input logic s);
      x       = b;
      sof     = s;
      x_valid = 1'b1;
   endtask

   task automatic bit_in(input logic b, input logic s);
      @(negedge clk);
      drive_now(b, s);
   endtask

   task automatic gap();
      @(negedge clk);
      x_valid = 1'b0;
      sof     = 1'b0;
      x       = 1'($urandom_range(0, 1));
   endtask

   task automatic end_frame();
      @(negedge clk);
      x_valid = 1'b0;
      sof     = 1'b0;
   endtask

   // Bits 1..7 plus parity of a frame whose bit 0 has already been driven.
   task automatic send_tail(input logic [7:0] d, input logic p);
      for (int i = 1; i < 8; i++) bit_in(d[i], 1'b0);
      bit_in(p, 1'b0);
   endtask

   // Full frame; with_gaps inserts i%6 idle cycles after data bit i and checks busy in them.
   task automatic send_frame(input logic [7:0] d, input logic p, input bit with_gaps);
      for (int i = 0; i < 8; i++) begin
         bit_in(d[i], (i == 0));
         if (with_gaps) begin
            for (int g = 0; g < (i % 6); g++) begin
               gap();
               check("gap_busy", 32'(busy), 32'd1);
            end
         end
      end
      bit_in(p, 1'b0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_data_out", 32'(data_out), 32'h0);
      check("rst_dv", 32'(data_valid), 32'h0);
      check("rst_par_err", 32'(par_err), 32'h0);
      check("rst_z", 32'(z), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
`ifdef PARITY_ERR_CNT_EN
      check("rst_err_count", 32'(err_count), 32'h0);
`endif
      rst_n = 1'b1;

      // 0xA5 with correct even parity
      dv_base = dv_cnt;
      send_frame(8'hA5, 1'b0, 1'b0);
      end_frame();
      check("a5_dv", 32'(data_valid), 32'd1);
      check("a5_data", 32'(data_out), 32'hA5);
      check("a5_par_err", 32'(par_err), 32'd0);
      check("a5_z", 32'(z), 32'd0);
      check("a5_busy", 32'(busy), 32'd0);
      check("a5_odd_par_err", 32'(par_err_o), 32'd1);
      @(negedge clk);
      check("a5_dv_one_cycle", 32'(data_valid), 32'd0);
      check("a5_dv_pulses", 32'(dv_cnt - dv_base), 32'd1);

      // IDLE ignores x_valid without sof, and sof without x_valid
      drive_now(1'b1, 1'b0);
      repeat (3) @(negedge clk);
      check("idle_nosof_busy", 32'(busy), 32'd0);
      check("idle_nosof_z", 32'(z), 32'd0);
      x_valid = 1'b0;
      sof     = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_sof_novalid_busy", 32'(busy), 32'd0);
      sof = 1'b0;
      check("idle_no_pulse", 32'(dv_cnt - dv_base), 32'd1);

      // 0xA5 with wrong parity
      send_frame(8'hA5, 1'b1, 1'b0);
      end_frame();
      check("a5p1_data", 32'(data_out), 32'hA5);
      check("a5p1_par_err", 32'(par_err), 32'd1);
      check("a5p1_z", 32'(z), 32'd1);
      check("a5p1_odd_par_err", 32'(par_err_o), 32'd0);
`ifdef PARITY_ERR_CNT_EN
      @(negedge clk);
      check("a5p1_err_count", 32'(err_count), 32'd1);
      check("a5p1_odd_err_count", 32'(err_count_o), 32'd1);
`endif

      // 0x3C with idle gaps between bits
      send_frame(8'h3C, 1'b0, 1'b1);
      end_frame();
      check("3c_data", 32'(data_out), 32'h3C);
      check("3c_par_err", 32'(par_err), 32'd0);
      check("3c_dv", 32'(data_valid), 32'd1);

      // Abort after 4 bits, new frame 0xFF
      @(negedge clk);
      dv_base = dv_cnt;
      bit_in(1'b0, 1'b1);
      bit_in(1'b1, 1'b0);
      bit_in(1'b1, 1'b0);
      bit_in(1'b0, 1'b0);
      send_frame(8'hFF, 1'b0, 1'b0);
      end_frame();
      check("abort_data", 32'(data_out), 32'hFF);
      check("abort_par_err", 32'(par_err), 32'd0);
      @(negedge clk);
      check("abort_dv_pulses", 32'(dv_cnt - dv_base), 32'd1);

      // Reset after 5 bits, then 0x01 with parity 1
      bit_in(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) bit_in(1'b1, 1'b0);
      @(negedge clk);
      x_valid = 1'b0;
      rst_n   = 1'b0;
      #1;
      check("midrst_data_out", 32'(data_out), 32'h0);
      check("midrst_z", 32'(z), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_dv", 32'(data_valid), 32'h0);
      check("midrst_par_err", 32'(par_err), 32'h0);
`ifdef PARITY_ERR_CNT_EN
      check("midrst_err_count", 32'(err_count), 32'h0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send_frame(8'h01, 1'b1, 1'b0);
      end_frame();
      check("postrst_data", 32'(data_out), 32'h01);
      check("postrst_par_err", 32'(par_err), 32'd0);
      check("postrst_dv", 32'(data_valid), 32'd1);

      // Back-to-back frames 0x12/0 and 0x34/1
      @(negedge clk);
      dv_base = dv_cnt;
      send_frame(8'h12, 1'b0, 1'b0);
      @(negedge clk);
      check("b2b_first_dv", 32'(data_valid), 32'd1);
      check("b2b_first_data", 32'(data_out), 32'h12);
      check("b2b_first_par_err", 32'(par_err), 32'd0);
      drive_now(1'b0, 1'b1);
      send_tail(8'h34, 1'b1);
      end_frame();
      check("b2b_second_dv", 32'(data_valid), 32'd1);
      check("b2b_second_data", 32'(data_out), 32'h34);
      check("b2b_second_par_err", 32'(par_err), 32'd0);
      @(negedge clk);
      check("b2b_dv_pulses", 32'(dv_cnt - dv_base), 32'd2);

`ifdef PARITY_ERR_CNT_EN
      // Saturation of the error counter
      for (int f = 0; f < 256; f++) send_frame(8'h00, 1'b1, 1'b0);
      end_frame();
      @(negedge clk);
      check("err_count_sat", 32'(err_count), 32'd255);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
